mux_sel_sequencer: RTL and testbench

//   Upstream driver for the 8:1 bit mux. Accepts 8-bit words over a valid/ready handshake,

---
 rtl/mux_seq_pkg.sv | 23 ++
 rtl/mux_sel_sequencer_bit_period_counter.sv | 46 ++++
 rtl/mux_sel_sequencer.sv | 97 +++++++++
 tb/tb_mux_sel_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mux_seq_pkg.sv
`timescale 1ns/1ps
// Shared types and select-order helpers for the bit-mux sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mux_seq_pkg;

    // Sequencer state: IDLE waits for a word, SHIFT walks the select across it.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Select index of the first bit of a word.
    function automatic int sel_start(input int width, input bit msb_first);
        return msb_first ? (width - 1) : 0;
    endfunction

    // Select index of the last bit of a word.
    function automatic int sel_end(input int width, input bit msb_first);
        return msb_first ? 0 : (width - 1);
    endfunction

endpackage

// File: rtl/mux_sel_sequencer_bit_period_counter.sv
`timescale 1ns/1ps
// Bit-period counter: paces how long each bit stays on the mux (DIV clocks minimum).
// Latency: adv_o is combinational once the count has reached DIV-1.
// Backpressure: count saturates at DIV-1 while out_ready_i is low; adv_o fires on its return.
//
// Ports: clk/rst_n clock and async active-low reset; en_i counts while high (SHIFT);
//        clr_i restarts the period (new word); out_ready_i downstream ready;
//        adv_o bit advance strobe.
module bit_period_counter #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    input  logic out_ready_i,
    output logic adv_o
);

    localparam int                CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_max;

    assign at_max = (cnt_q == CNT_MAX);
    assign adv_o  = en_i && at_max && out_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i || adv_o) begin
            cnt_d = '0;
        end else if (!at_max) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_sel_sequencer.sv
`timescale 1ns/1ps
// Word-to-bit sequencer: holds a word on the mux inputs and steps the select across it.
// Latency: first bit valid one clock after word accept; back-to-back words have no bubble.
// Backpressure: out_ready low freezes mux_s/mux_i; in_ready only on IDLE or last-bit advance.
//
// Ports: clk/rst_n clock and async active-low reset;
//        in_data/in_valid/in_ready word input handshake;
//        mux_i/mux_s mux data and select; bit_valid/bit_first/bit_last bit framing;
//        out_ready downstream bit accept; busy word in flight.
module mux_sel_sequencer
    import mux_seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SEL_W     = 3,
    parameter bit MSB_FIRST = 1'b0,
    parameter int DIV       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] mux_i,
    output logic [SEL_W-1:0] mux_s,
    output logic             bit_valid,
    output logic             bit_first,
    output logic             bit_last,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [SEL_W-1:0] SEL_START = SEL_W'(sel_start(WIDTH, MSB_FIRST));
    localparam logic [SEL_W-1:0] SEL_END   = SEL_W'(sel_end(WIDTH, MSB_FIRST));

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [SEL_W-1:0] sel_q, sel_d;

    logic in_shift;
    logic adv;
    logic adv_last;
    logic accept;

    assign in_shift = (state_q == SHIFT);
    assign bit_last = in_shift && (sel_q == SEL_END);
    assign adv_last = adv && bit_last;
    // Ready on the last-bit advance lets the next word follow with no idle clock.
    assign in_ready = !in_shift || adv_last;
    assign accept   = in_valid && in_ready;

    bit_period_counter #(
        .DIV (DIV)
    ) u_bit_period_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (in_shift),
        .clr_i       (accept),
        .out_ready_i (out_ready),
        .adv_o       (adv)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        sel_d   = sel_q;
        if (accept) begin
            word_d  = in_data;
            sel_d   = SEL_START;
            state_d = SHIFT;
        end else if (adv_last) begin
            // Park the select at the start index so idle looks like reset.
            sel_d   = SEL_START;
            state_d = IDLE;
        end else if (adv) begin
            sel_d = MSB_FIRST ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            sel_q   <= SEL_START;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            sel_q   <= sel_d;
        end
    end

    assign mux_i     = word_q;
    assign mux_s     = sel_q;
    assign bit_valid = in_shift;
    assign bit_first = in_shift && (sel_q == SEL_START);
    assign busy      = in_shift;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
`timescale 1ns/1ps
// Directed bench for mux_sel_sequencer: instance a (DIV=1, LSB first),
// instance b (DIV=3, MSB first). Inputs change and outputs are sampled on negedge.
module tb_mux_sel_sequencer;

    logic clk;
    logic rst_n;

    logic [7:0] a_in_data;
    logic       a_in_valid;
    logic       a_in_ready;
    logic [7:0] a_mux_i;
    logic [2:0] a_mux_s;
    logic       a_bit_valid, a_bit_first, a_bit_last;
    logic       a_out_ready;
    logic       a_busy;

    logic [7:0] b_in_data;
    logic       b_in_valid;
    logic       b_in_ready;
    logic [7:0] b_mux_i;
    logic [2:0] b_mux_s;
    logic       b_bit_valid, b_bit_first, b_bit_last;
    logic       b_out_ready;
    logic       b_busy;

    int checks;
    int failures;

    mux_sel_sequencer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b0), .DIV(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .mux_i(a_mux_i), .mux_s(a_mux_s),
        .bit_valid(a_bit_valid), .bit_first(a_bit_first), .bit_last(a_bit_last),
        .out_ready(a_out_ready), .busy(a_busy)
    );

    mux_sel_sequencer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b1), .DIV(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .mux_i(b_mux_i), .mux_s(b_mux_s),
        .bit_valid(b_bit_valid), .bit_first(b_bit_first), .bit_last(b_bit_last),
        .out_ready(b_out_ready), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Full per-bit check of instance a against a hand-derived word and position.
    task automatic chk_a_bit(input string tag, input logic [7:0] word, input int k,
                             input logic exp_rdy);
        logic [7:0] w;
        w = word;
        chk({tag, "_vld"},   a_bit_valid, 1'b1);
        chk({tag, "_sel"},   a_mux_s, k);
        chk({tag, "_word"},  a_mux_i, word);
        chk({tag, "_first"}, a_bit_first, (k == 0));
        chk({tag, "_last"},  a_bit_last, (k == 7));
        chk({tag, "_ser"},   a_mux_i[a_mux_s], w[k]);
        chk({tag, "_rdy"},   a_in_ready, exp_rdy);
    endtask

    initial begin
        logic [7:0] exp_ser_a5;
        logic [7:0] exp_ser_81;
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        a_in_data   = '0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        b_in_data   = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        // Serial order of 8'hA5 LSB first: 1,0,1,0,0,1,0,1 (index = bit time).
        exp_ser_a5  = 8'b1010_0101;
        // 8'h81 MSB first: 1 at sel 7 and sel 0 only.
        exp_ser_81  = 8'b1000_0001;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_rdy",  a_in_ready, 1'b1);
        chk("rst_vld",  a_bit_valid, 1'b0);
        chk("rst_sel",  a_mux_s, 3'd0);
        chk("rst_word", a_mux_i, 8'h00);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_b_sel", b_mux_s, 3'd7);

        // Single word A5, DIV=1
        a_in_data  = 8'hA5;
        a_in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk_a_bit("a5", 8'hA5, k, (k == 7));
            chk("a5_serial", a_mux_i[a_mux_s], exp_ser_a5[k]);
            a_in_valid = 1'b0;
        end
        @(negedge clk);
        chk("a5_idle_vld",  a_bit_valid, 1'b0);
        chk("a5_idle_busy", a_busy, 1'b0);
        chk("a5_idle_rdy",  a_in_ready, 1'b1);

        // Back-to-back FF then 00, in_valid held until the second word is taken
        a_in_data  = 8'hFF;
        a_in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk_a_bit("b2b", (i < 8) ? 8'hFF : 8'h00, i % 8, ((i % 8) == 7));
            chk("b2b_ser", a_mux_i[a_mux_s], (i < 8) ? 1'b1 : 1'b0);
            a_in_data = 8'h00;
            if (i >= 8) a_in_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b_end_vld", a_bit_valid, 1'b0);

        // Backpressure at sel 3 for 4 clocks
        a_in_data  = 8'h3C;
        a_in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_a_bit("bp_pre", 8'h3C, k, 1'b0);
            a_in_valid = 1'b0;
        end
        a_out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("bp_hold_sel",  a_mux_s, 3'd3);
            chk("bp_hold_word", a_mux_i, 8'h3C);
            chk("bp_hold_vld",  a_bit_valid, 1'b1);
            chk("bp_hold_rdy",  a_in_ready, 1'b0);
        end
        a_out_ready = 1'b1;
        for (int k = 4; k < 8; k++) begin
            @(negedge clk);
            chk_a_bit("bp_post", 8'h3C, k, (k == 7));
        end
        @(negedge clk);
        chk("bp_end_vld", a_bit_valid, 1'b0);

        // DIV=3, MSB first, 8'h81: 24 valid clocks, sel 7..0 each held 3
        b_in_data  = 8'h81;
        b_in_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            chk("div_vld",   b_bit_valid, 1'b1);
            chk("div_sel",   b_mux_s, 7 - (c / 3));
            chk("div_first", b_bit_first, (c < 3));
            chk("div_last",  b_bit_last, (c >= 21));
            chk("div_ser",   b_mux_i[b_mux_s], exp_ser_81[7 - (c / 3)]);
            chk("div_rdy",   b_in_ready, (c == 23));
            b_in_valid = 1'b0;
        end
        @(negedge clk);
        chk("div_end_vld", b_bit_valid, 1'b0);
        chk("div_end_sel", b_mux_s, 3'd7);

        // Reset mid-word at sel 5, asserted between clock edges
        a_in_data  = 8'h5A;
        a_in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("mid_sel", a_mux_s, k);
            a_in_valid = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_sel",  a_mux_s, 3'd0);
        chk("mid_rst_word", a_mux_i, 8'h00);
        chk("mid_rst_vld",  a_bit_valid, 1'b0);
        chk("mid_rst_busy", a_busy, 1'b0);
        chk("mid_rst_rdy",  a_in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        a_in_data  = 8'h0F;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        chk_a_bit("post_rst", 8'h0F, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
